// File: rtl/_divider.sv
// _divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
module _divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q, d, r;
  logic [WIDTH:0] rs, t;
  logic neg_q, neg_r, sd, sv;
  always_comb begin
    sd = is_signed & dividend[WIDTH-1];
    sv = is_signed & divisor[WIDTH-1];
    rs = {r, q[WIDTH-1]};
    t = rs - {1'b0, d};
  end
  // A zero divisor leaves Q all ones and R equal to |dividend|, so only the quotient sign needs overriding.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      cnt <= '0;
      q <= '0;
      d <= '0;
      r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          busy <= 1'b1;
          q <= sd ? -dividend : dividend;
          d <= sv ? -divisor : divisor;
          r <= '0;
          cnt <= '0;
          neg_q <= sd ^ sv;
          neg_r <= sd;
        end
        CALC: begin
          r <= t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~t[WIDTH]};
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(WIDTH - 1) ? FIX : CALC;
        end
        FIX: begin
          quotient <= d == '0 ? '1 : neg_q ? -q : q;
          remainder <= neg_r ? -r : r;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: doc/_divider.md
# _divider

Multi-cycle 32-bit integer divider, the subtract-direction counterpart of the combinational adder path: it computes quotient and remainder by restoring shift-and-subtract, one quotient bit per clock. Sits beside the ALU in the execute stage and serves RV32M DIV/DIVU/REM/REMU. A start/busy/done handshake stalls the pipeline for the fixed operation latency.

## Interface
- WIDTH, 32, operand/result width; all arithmetic below is for WIDTH=32.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- is_signed  input  1  1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; quotient/remainder valid in this cycle and held afterwards.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.

## Operation
- States: IDLE, CALC, FIX, DONE. 5-bit iteration counter.
- IDLE: if start=1 at an edge, latch operands, is_signed, sign flags (signed mode: sign = MSB; unsigned: 0); load magnitude of dividend into Q register, magnitude of divisor into D, clear 33-bit partial remainder R, counter=0; go CALC. Else stay.
- CALC, each edge: shift {R,Q} left by one; T = R_shifted - {1'b0,D} (33-bit); if T MSB=0 then R=T, Q LSB=1, else R unchanged, Q LSB=0. Counter increments; after the 32nd iteration (counter was 31) go FIX.
- FIX, one edge: compute final results into quotient/remainder registers, go DONE:
  - divisor==0: quotient = 32'hFFFF_FFFF, remainder = original dividend (both modes).
  - signed, dividend=32'h8000_0000, divisor=32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0.
  - otherwise: quotient = Q, negated if signs differ; remainder = R[31:0], negated if dividend negative.
- DONE: done=1 for one cycle, then IDLE on next edge unconditionally.
- start while busy: ignored, no queueing; start in DONE cycle is also ignored (accepted only from IDLE).
- quotient/remainder change only on the FIX edge; stable from done until next FIX.
- Magnitude of 32'h8000_0000 is 2^31, representable in the 32-bit unsigned datapath; no widening beyond R's 33 bits.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0; overrides start and any in-flight operation (mid-CALC reset aborts, results not updated).
- start sampled high at edge E: busy=1 from E; CALC edges E+1..E+32; FIX edge E+33; done=1 from E+33 to E+34; busy falls at E+34.
- Fixed latency 34 cycles start-to-idle regardless of operand values, including divide-by-zero and overflow.
- Earliest back-to-back start: sampled at edge E+34 (first IDLE cycle).
- done and busy are registered state decodes; no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, is_signed=0, start at edge E -> done only at E+33..E+34, quotient=14, remainder=2; busy high exactly 34 cycles.
- Signed -7 / 2 (32'hFFFF_FFF9, 2) -> quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1); unsigned same operands -> quotient=32'h7FFF_FFFC, remainder=1.
- Divide by zero: signed 32'h8000_0005 / 0 -> quotient=32'hFFFF_FFFF, remainder=32'h8000_0005; unsigned 0 / 0 -> quotient=32'hFFFF_FFFF, remainder=0.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0; unsigned 32'hFFFF_FFFF / 1 -> quotient=32'hFFFF_FFFF, remainder=0.
- Handshake: start pulsed again at E+10 and at the done cycle with different operands -> ignored, first result unchanged; start at E+34 accepted, new done at E+67.
- Reset mid-operation: rst_n=0 at E+15 -> next cycle busy=0, done=0, quotient=remainder=0; no done pulse follows; fresh start afterwards completes normally with correct results.
